ahb_burst_master: RTL and testbench

Parametrised AHB master: next generation of the single-transfer AHB master. Accepts burst commands (SINGLE/INCR4/INCR8/INCR16) from a local client. Pipelines address and data phases with HREADY wait-state support, and buffers write data in an internal FIFO. Aborts cleanly on non-OKAY responses. Sits between DMA/CPU-side request logic and the AHB interconnect.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/ahb_wr_fifo.sv | 39 +++
 rtl/ahb_burst_master.sv | 126 ++++++++++++
 tb/tb_ahb_burst_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB codes, master FSM states and burst helpers.
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11} htrans_e;
  typedef enum logic [2:0] {HBURST_SINGLE = 3'b000, HBURST_INCR4 = 3'b011, HBURST_INCR8 = 3'b101, HBURST_INCR16 = 3'b111} hburst_e;
  typedef enum logic [1:0] {HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01, HRESP_RETRY = 2'b10, HRESP_SPLIT = 2'b11} hresp_e;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAITW = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_SEQ = 3'd3;
  localparam logic [2:0] S_LAST = 3'd4;
  localparam logic [2:0] S_ERR = 3'd5;
  // Zero marks an unsupported burst encoding.
  function automatic logic [4:0] burst_beats(input logic [2:0] b);
    return b == HBURST_SINGLE ? 5'd1 : b == HBURST_INCR4 ? 5'd4 : b == HBURST_INCR8 ? 5'd8 : b == HBURST_INCR16 ? 5'd16 : 5'd0;
  endfunction
endpackage

// File: rtl/ahb_wr_fifo.sv
// ahb_wr_fifo: write-data buffer with push/pop and a bulk flush of N entries.
module ahb_wr_fifo #(
  parameter int DATA_W = 32,
  parameter int WFIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  input  logic [$clog2(WFIFO_DEPTH):0]   flush_n,
  output logic [DATA_W-1:0]              head,
  output logic [$clog2(WFIFO_DEPTH):0]   count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [WFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = count == CW'(WFIFO_DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_ok) + flush_n[AW-1:0];
      count <= count + CW'(push_ok) - CW'(pop_ok) - flush_n;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: burst AHB master with pipelined address/data phases,
// buffered write data and clean abort on non-OKAY responses.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WFIFO_DEPTH = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA
);
  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  logic [2:0] state;
  logic [4:0] beats, cnt, cmd_beats;
  logic [11:0] cmd_end;
  logic [CW-1:0] fifo_count, avail, flush_n;
  logic [DATA_W-1:0] fifo_head;
  logic fifo_full, fifo_empty, fifo_pop, wr_push;
  logic reject, accept, dphase, resp_ok, beat_done, abort;
  ahb_wr_fifo #(.DATA_W(DATA_W), .WFIFO_DEPTH(WFIFO_DEPTH)) u_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(wr_valid), .push_data(wr_data), .pop(fifo_pop),
    .flush_n(flush_n), .head(fifo_head), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );
  // A burst is rejected if its last byte would land past the current 1 KB page.
  assign cmd_beats = burst_beats(cmd_burst);
  assign cmd_end = {2'b00, cmd_addr[9:0]} + (12'(cmd_beats) << cmd_size);
  assign reject = cmd_beats == 5'd0 || cmd_size > 3'(MAX_SIZE) || cmd_end > 12'd1024;
  assign accept = cmd_valid && cmd_ready;
  assign wr_ready = !fifo_full;
  assign wr_push = wr_valid && wr_ready;
  assign avail = fifo_count + CW'(wr_push);
  assign dphase = state == S_SEQ || state == S_LAST;
  assign resp_ok = HRESP == HRESP_OKAY;
  assign beat_done = dphase && HREADY && resp_ok;
  assign abort = dphase && !resp_ok;
  assign fifo_pop = beat_done && HWRITE && !fifo_empty;
  assign flush_n = (abort && HWRITE) ? CW'(beats - cnt) : '0;
  // An error response cancels the pending address phase in the same cycle.
  assign HTRANS = state == S_ADDR ? HTRANS_NONSEQ : (state == S_SEQ && resp_ok) ? HTRANS_SEQ : HTRANS_IDLE;
  assign HWDATA = (dphase && HWRITE) ? fifo_head : '0;
  assign HPROT = HPROT_DEFAULT;
  assign cmd_ready = state == S_IDLE && !done;
  always_ff @(posedge HCLK)
    if (!HRESETn) begin
      state <= S_IDLE;
      HADDR <= '0;
      HWRITE <= 1'b0;
      HSIZE <= '0;
      HBURST <= '0;
      beats <= '0;
      cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      rd_valid <= beat_done && !HWRITE;
      if (beat_done && !HWRITE) rd_data <= HRDATA;
      if (abort) begin
        state <= HREADY ? S_IDLE : S_ERR;
        done <= 1'b1;
        err <= 1'b1;
      end else
        case (state)
          S_IDLE:
            if (accept && reject) begin
              done <= 1'b1;
              err <= 1'b1;
            end else if (accept) begin
              HADDR <= cmd_addr;
              HWRITE <= cmd_write;
              HSIZE <= cmd_size;
              HBURST <= cmd_burst;
              beats <= cmd_beats;
              cnt <= '0;
              state <= (!cmd_write || avail >= CW'(cmd_beats)) ? S_ADDR : S_WAITW;
            end
          S_WAITW: if (avail >= CW'(beats)) state <= S_ADDR;
          S_ADDR:
            if (HREADY) begin
              HADDR <= HADDR + (ADDR_W'(1) << HSIZE);
              state <= beats == 5'd1 ? S_LAST : S_SEQ;
            end
          S_SEQ:
            if (HREADY) begin
              HADDR <= HADDR + (ADDR_W'(1) << HSIZE);
              cnt <= cnt + 5'd1;
              state <= (cnt + 5'd2 == beats) ? S_LAST : S_SEQ;
            end
          S_LAST:
            if (HREADY) begin
              cnt <= cnt + 5'd1;
              done <= 1'b1;
              state <= S_IDLE;
            end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed scenarios for the burst AHB master with a
// scripted slave and hand-computed expectations.
module tb_ahb_burst_master;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0] cmd_burst = '0, cmd_size = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic rd_valid, done, err;
  logic [31:0] rd_data, HADDR, HWDATA, HRDATA = '0;
  logic HWRITE, HREADY = 1'b1;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS, HRESP = 2'b00;
  int n_cmp = 0, n_bad = 0;
  logic [2:0] rej_burst [4] = '{3'b001, 3'b111, 3'b111, 3'b011};
  logic [2:0] rej_size [4] = '{3'd2, 3'd3, 3'd2, 3'd2};
  logic [31:0] rej_addr [4] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_03F0, 32'h4000_03F4};

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32), .WFIFO_DEPTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .err(err), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data = d;
    cyc;
    wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [2:0] b, input logic [2:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_burst = b;
    cmd_size = s;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_before_accept got %b want 1", cmd_ready); end
    cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    cyc;
    cyc;
    n_cmp++;
    if ({HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT} !== {2'b00, 32'h0, 32'h0, 1'b0, 3'd0, 3'd0, 4'b0011}) begin
      n_bad++; $display("FAIL reset_bus got %h want %h", {HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT}, {2'b00, 32'h0, 32'h0, 1'b0, 3'd0, 3'd0, 4'b0011});
    end
    n_cmp++;
    if ({cmd_ready, wr_ready, rd_valid, done, err} !== 5'b11000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 11000", {cmd_ready, wr_ready, rd_valid, done, err});
    end
    HRESETn = 1'b1;
    cyc;
  endtask

  task automatic test_write_single;
    push(32'hA5A5_A5A5);
    send_cmd(1'b1, 32'h4000_0000, 3'b000, 3'd2);
    n_cmp++;
    if ({HTRANS, HWRITE, HADDR, HSIZE, HBURST, cmd_ready} !== {2'b10, 1'b1, 32'h4000_0000, 3'd2, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL ws_addr_phase got %h want %h", {HTRANS, HWRITE, HADDR, HSIZE, HBURST, cmd_ready}, {2'b10, 1'b1, 32'h4000_0000, 3'd2, 3'd0, 1'b0});
    end
    cyc;
    n_cmp++;
    if ({HTRANS, HWDATA} !== {2'b00, 32'hA5A5_A5A5}) begin n_bad++; $display("FAIL ws_data_phase got %h want %h", {HTRANS, HWDATA}, {2'b00, 32'hA5A5_A5A5}); end
    cyc;
    n_cmp++;
    if ({done, err, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL ws_done got %b want 100", {done, err, cmd_ready}); end
    cyc;
    n_cmp++;
    if ({done, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL ws_ready_again got %b want 01", {done, cmd_ready}); end
  endtask

  task automatic test_read_incr4;
    send_cmd(1'b0, 32'h4000_0010, 3'b011, 3'd2);
    for (int i = 1; i <= 6; i++) begin
      HRDATA = (i >= 2 && i <= 5) ? 32'hDEAD_BEE0 + 32'(i - 2) : 32'h0;
      n_cmp++;
      if (HTRANS !== (i == 1 ? 2'b10 : i <= 4 ? 2'b11 : 2'b00)) begin n_bad++; $display("FAIL rd4_htrans cycle %0d got %b", i, HTRANS); end
      if (i <= 4) begin
        n_cmp++;
        if (HADDR !== 32'h4000_0010 + 32'(4 * (i - 1))) begin n_bad++; $display("FAIL rd4_haddr cycle %0d got %h want %h", i, HADDR, 32'h4000_0010 + 32'(4 * (i - 1))); end
      end
      n_cmp++;
      if ({rd_valid, done} !== {(i >= 3), (i == 6)}) begin n_bad++; $display("FAIL rd4_strobes cycle %0d got %b want %b", i, {rd_valid, done}, {(i >= 3), (i == 6)}); end
      if (i >= 3) begin
        n_cmp++;
        if (rd_data !== 32'hDEAD_BEE0 + 32'(i - 3)) begin n_bad++; $display("FAIL rd4_data cycle %0d got %h want %h", i, rd_data, 32'hDEAD_BEE0 + 32'(i - 3)); end
      end
      cyc;
    end
    n_cmp++;
    if ({rd_valid, err, cmd_ready} !== 3'b001) begin n_bad++; $display("FAIL rd4_after got %b want 001", {rd_valid, err, cmd_ready}); end
  endtask

  task automatic test_write_incr8_wait;
    int a = 0, d = -1, waits = 0, n = 0;
    bit fin = 1'b0;
    for (int k = 0; k < 8; k++) push(32'h1000_0000 + 32'(k));
    send_cmd(1'b1, 32'h4000_0100, 3'b101, 3'd2);
    while (!fin && n < 40) begin
      HREADY = !(d == 2 && waits < 2);
      if (!HREADY) waits++;
      #1;
      n_cmp++;
      if ({HTRANS, done} !== {(a == 0 ? 2'b10 : a < 8 ? 2'b11 : 2'b00), 1'b0}) begin n_bad++; $display("FAIL wr8_htrans a=%0d got %b", a, {HTRANS, done}); end
      if (a < 8) begin
        n_cmp++;
        if (HADDR !== 32'h4000_0100 + 32'(4 * a)) begin n_bad++; $display("FAIL wr8_haddr a=%0d got %h want %h", a, HADDR, 32'h4000_0100 + 32'(4 * a)); end
      end
      if (d >= 0) begin
        n_cmp++;
        if (HWDATA !== 32'h1000_0000 + 32'(d)) begin n_bad++; $display("FAIL wr8_hwdata d=%0d got %h want %h", d, HWDATA, 32'h1000_0000 + 32'(d)); end
      end
      cyc;
      n++;
      if (HREADY) begin
        if (a >= 8) fin = 1'b1;
        d = a;
        a++;
      end
    end
    HREADY = 1'b1;
    n_cmp++;
    if (!fin || {done, err} !== 2'b10) begin n_bad++; $display("FAIL wr8_done got %b fin=%0d want 10", {done, err}, fin); end
    cyc;
  endtask

  task automatic test_read_error;
    send_cmd(1'b0, 32'h4000_0020, 3'b011, 3'd2);
    n_cmp++;
    if (HTRANS !== 2'b10) begin n_bad++; $display("FAIL rerr_nonseq got %b want 10", HTRANS); end
    cyc;
    HRDATA = 32'h1111_0000;
    cyc;
    HREADY = 1'b0;
    HRESP = 2'b01;
    HRDATA = 32'hBAD0_BAD0;
    #1;
    n_cmp++;
    if ({HTRANS, rd_valid} !== 3'b001) begin n_bad++; $display("FAIL rerr_cancel got %b want 001", {HTRANS, rd_valid}); end
    n_cmp++;
    if (rd_data !== 32'h1111_0000) begin n_bad++; $display("FAIL rerr_beat1 got %h want 11110000", rd_data); end
    cyc;
    HREADY = 1'b1;
    n_cmp++;
    if ({done, err, rd_valid, HTRANS} !== 5'b11000) begin n_bad++; $display("FAIL rerr_done got %b want 11000", {done, err, rd_valid, HTRANS}); end
    cyc;
    HRESP = 2'b00;
    n_cmp++;
    if ({done, rd_valid, cmd_ready, HTRANS} !== 5'b00100) begin n_bad++; $display("FAIL rerr_after got %b want 00100", {done, rd_valid, cmd_ready, HTRANS}); end
  endtask

  task automatic test_reject;
    for (int r = 0; r < 4; r++) begin
      send_cmd(1'b0, rej_addr[r], rej_burst[r], rej_size[r]);
      n_cmp++;
      if ({HTRANS, done, err, cmd_ready} !== 5'b00110) begin n_bad++; $display("FAIL reject_%0d got %b want 00110", r, {HTRANS, done, err, cmd_ready}); end
      cyc;
      n_cmp++;
      if ({HTRANS, done, cmd_ready} !== 4'b0001) begin n_bad++; $display("FAIL reject_after_%0d got %b want 0001", r, {HTRANS, done, cmd_ready}); end
    end
  endtask

  task automatic test_waitw;
    for (int k = 0; k < 3; k++) push(32'hCAFE_0000 + 32'(k));
    send_cmd(1'b1, 32'h4000_0200, 3'b011, 3'd2);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({HTRANS, cmd_ready} !== 3'b000) begin n_bad++; $display("FAIL waitw_hold %0d got %b want 000", k, {HTRANS, cmd_ready}); end
      cyc;
    end
    push(32'hCAFE_0003);
    n_cmp++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0200}) begin n_bad++; $display("FAIL waitw_start got %h want %h", {HTRANS, HADDR}, {2'b10, 32'h4000_0200}); end
    cyc;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if ({HTRANS, HWDATA} !== {(j < 3 ? 2'b11 : 2'b00), 32'hCAFE_0000 + 32'(j)}) begin
        n_bad++; $display("FAIL waitw_beat %0d got %h want %h", j, {HTRANS, HWDATA}, {(j < 3 ? 2'b11 : 2'b00), 32'hCAFE_0000 + 32'(j)});
      end
      cyc;
    end
    n_cmp++;
    if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL waitw_done got %b want 10", {done, err}); end
    cyc;
  endtask

  task automatic test_reset_mid;
    send_cmd(1'b0, 32'h4000_0040, 3'b011, 3'd2);
    n_cmp++;
    if (HTRANS !== 2'b10) begin n_bad++; $display("FAIL rmid_nonseq got %b want 10", HTRANS); end
    HRESETn = 1'b0;
    cyc;
    n_cmp++;
    if ({HTRANS, done, cmd_ready} !== 4'b0001) begin n_bad++; $display("FAIL rmid_idle got %b want 0001", {HTRANS, done, cmd_ready}); end
    HRESETn = 1'b1;
    cyc;
    n_cmp++;
    if ({HTRANS, done, rd_valid} !== 4'b0000) begin n_bad++; $display("FAIL rmid_after got %b want 0000", {HTRANS, done, rd_valid}); end
  endtask

  initial begin
    test_reset;
    test_write_single;
    test_read_incr4;
    test_write_incr8_wait;
    test_read_error;
    test_reject;
    test_waitw;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
